video_mode_ctrl: RTL and testbench

Frame-rate controller that sequences the video conditioning path across VDP mode changes. It measures active line width and samples VDP mode bits once per frame, then qualifies a new mode only after it has been stable for several consecutive frames. It then commits the new `res_h`/`res_v`/`pal`/`interlace` configuration to the conditioning and aspect-ratio logic and forces blanking for a fixed number of frames, so the scaler never sees a half-switched mode. It sits between the VDP outputs and the video conditioning block.

---
 rtl/video_mode_pkg.sv | 24 ++
 rtl/line_width_meter.sv | 41 ++++
 rtl/video_mode_ctrl.sv | 179 +++++++++++++++++
 tb/tb_video_mode_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mode_pkg.sv
// Shared types and constants for the video mode sequencing path.
package video_mode_pkg;

  localparam int unsigned PCNT_W  = 9;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned W256_TH = 252;
  localparam int unsigned W320_TH = 300;

  typedef struct packed {
    logic [1:0] res_h;
    logic [1:0] res_v;
    logic       pal;
    logic       interlace;
  } vmode_t;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    PENDING = 2'd1,
    MUTE    = 2'd2
  } vmc_state_t;

  localparam vmode_t VMODE_RESET = '{res_h: 2'd2, res_v: 2'd2, pal: 1'b0, interlace: 1'b0};

endpackage

// File: rtl/line_width_meter.sv
// Counts enabled display pixels per line and keeps the widest line of the current frame.
module line_width_meter
  import video_mode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              de,
  input  logic              hs_fall,
  input  logic              fev,
  output logic [PCNT_W-1:0] wmax
);

  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] fold_c;

  assign fold_c = (pcnt > wmax) ? pcnt : wmax;

  // A line folded on the frame-event cycle belongs to the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      wmax <= '0;
    end else begin
      if (hs_fall) begin
        pcnt <= '0;
      end else if (ce_pix && de && (pcnt != PCNT_MAX)) begin
        pcnt <= pcnt + PCNT_W'(1);
      end

      if (fev) begin
        wmax <= hs_fall ? pcnt : '0;
      end else if (hs_fall) begin
        wmax <= fold_c;
      end
    end
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// Qualifies VDP mode changes over several frames, commits them and blanks output during the switch.
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned MUTE_FRAMES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       vdp_de_h,
  input  logic       vdp_m2,
  input  logic       vdp_m5,
  input  logic       vdp_intfield,
  input  logic       pal,
  output logic [1:0] res_h,
  output logic [1:0] res_v,
  output logic       pal_out,
  output logic       interlace,
  output logic       blank_force,
  output logic       mode_stb
);

  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] MUTE_N   = CNT_W'(MUTE_FRAMES);

  logic              hs_d, vs_d, fev;
  logic              hs_fall_c, vs_fall_c;
  logic [PCNT_W-1:0] wmax;
  logic              int_prev, int_valid;

  vmc_state_t        state_q, state_d;
  vmode_t            cur_q, cur_d, cand_q, cand_d, cand_c, commit_src_c;
  logic [CNT_W-1:0]  stab_q, stab_d, mute_q, mute_d;
  logic              blank_q, blank_d, stb_q, stb_d, commit_c;

  assign hs_fall_c = hs_d & ~hs_in;
  assign vs_fall_c = vs_d & ~vs_in;

  // Sync edge detection, frame event and field history.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d      <= 1'b1;
      vs_d      <= 1'b1;
      fev       <= 1'b0;
      int_prev  <= 1'b0;
      int_valid <= 1'b0;
    end else begin
      hs_d <= hs_in;
      vs_d <= vs_in;
      fev  <= vs_fall_c;
      if (fev) begin
        int_prev  <= vdp_intfield;
        int_valid <= 1'b1;
      end
    end
  end

  line_width_meter u_meter (
    .clk     (clk),
    .reset   (reset),
    .ce_pix  (ce_pix),
    .de      (vdp_de_h),
    .hs_fall (hs_fall_c),
    .fev     (fev),
    .wmax    (wmax)
  );

  // Mode candidate for the frame just closed; a frame with no pixels keeps the current width.
  always_comb begin
    cand_c = cur_q;
    if (wmax > PCNT_W'(W320_TH)) begin
      cand_c.res_h = 2'd2;
    end else if (wmax > PCNT_W'(W256_TH)) begin
      cand_c.res_h = 2'd1;
    end else if (wmax != '0) begin
      cand_c.res_h = 2'd0;
    end
    if (!vdp_m5) begin
      cand_c.res_v = 2'd0;
    end else if (!vdp_m2) begin
      cand_c.res_v = 2'd1;
    end else begin
      cand_c.res_v = 2'd2;
    end
    cand_c.pal       = pal;
    cand_c.interlace = int_valid & (vdp_intfield ^ int_prev);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOCKED;
      cur_q   <= VMODE_RESET;
      cand_q  <= VMODE_RESET;
      stab_q  <= '0;
      mute_q  <= '0;
      blank_q <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      mute_q  <= mute_d;
      blank_q <= blank_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    cand_d       = cand_q;
    stab_d       = stab_q;
    mute_d       = mute_q;
    blank_d      = blank_q;
    stb_d        = 1'b0;
    commit_c     = 1'b0;
    commit_src_c = cand_q;

    if (fev) begin
      case (state_q)
        LOCKED: begin
          if (cand_c != cur_q) begin
            if (STABLE_N == CNT_W'(1)) begin
              commit_c     = 1'b1;
              commit_src_c = cand_c;
            end else begin
              cand_d  = cand_c;
              stab_d  = CNT_W'(1);
              state_d = PENDING;
            end
          end
        end
        PENDING: begin
          if (cand_c == cur_q) begin
            stab_d  = '0;
            state_d = LOCKED;
          end else if (cand_c != cand_q) begin
            cand_d = cand_c;
            stab_d = CNT_W'(1);
          end else begin
            stab_d = stab_q + CNT_W'(1);
            if (stab_q + CNT_W'(1) == STABLE_N) begin
              commit_c = 1'b1;
            end
          end
        end
        MUTE: begin
          mute_d = mute_q + CNT_W'(1);
          if (mute_q + CNT_W'(1) == MUTE_N) begin
            blank_d = 1'b0;
            state_d = LOCKED;
          end
        end
        default: state_d = LOCKED;
      endcase
    end

    if (commit_c) begin
      cur_d   = commit_src_c;
      stb_d   = 1'b1;
      blank_d = 1'b1;
      mute_d  = '0;
      stab_d  = '0;
      state_d = MUTE;
    end
  end

  assign res_h       = cur_q.res_h;
  assign res_v       = cur_q.res_v;
  assign pal_out     = cur_q.pal;
  assign interlace   = cur_q.interlace;
  assign blank_force = blank_q;
  assign mode_stb    = stb_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Scoreboard bench for video_mode_ctrl: frame-level reference model feeds queues checked by monitors.
module tb_video_mode_ctrl;

  localparam int STABLE = 3;
  localparam int MUTEF  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic       vdp_de_h = 1'b0;
  logic       vdp_m2 = 1'b1;
  logic       vdp_m5 = 1'b1;
  logic       vdp_intfield = 1'b0;
  logic       pal = 1'b0;
  logic [1:0] res_h, res_v;
  logic       pal_out, interlace, blank_force, mode_stb;

  int vectors = 0;
  int miscompares = 0;

  // Expected per-frame state {res_h,res_v,pal,interlace,blank,stb} and committed modes.
  logic [7:0] frame_q[$];
  logic [5:0] commit_q[$];

  // Reference model state, frame granularity.
  logic [5:0] m_cur;
  logic [5:0] m_last;
  bit         m_blank;
  int         m_run;
  int         m_mute_left;
  bit         m_prev_int;
  bit         m_int_valid;
  bit         itf = 1'b0;

  video_mode_ctrl #(.STABLE_FRAMES(STABLE), .MUTE_FRAMES(MUTEF)) dut (
    .clk          (clk),
    .reset        (reset),
    .ce_pix       (ce_pix),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .vdp_de_h     (vdp_de_h),
    .vdp_m2       (vdp_m2),
    .vdp_m5       (vdp_m5),
    .vdp_intfield (vdp_intfield),
    .pal          (pal),
    .res_h        (res_h),
    .res_v        (res_v),
    .pal_out      (pal_out),
    .interlace    (interlace),
    .blank_force  (blank_force),
    .mode_stb     (mode_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cur       = 6'b10_10_0_0;
    m_last      = 6'b10_10_0_0;
    m_blank     = 1'b0;
    m_run       = 0;
    m_mute_left = 0;
    m_prev_int  = 1'b0;
    m_int_valid = 1'b0;
  endfunction

  function automatic int cap(input int w);
    return (w > 511) ? 511 : w;
  endfunction

  // One frame boundary: classify the frame, then apply the stability/mute rules.
  function automatic void model_frame(input int wa, input int wb, input bit m5, input bit m2,
                                      input bit intf, input bit p);
    int         wm;
    logic [1:0] rh, rv;
    bit         il, stb;
    logic [5:0] cand;
    wm = (cap(wa) > cap(wb)) ? cap(wa) : cap(wb);
    if (wm > 300)      rh = 2'd2;
    else if (wm > 252) rh = 2'd1;
    else if (wm != 0)  rh = 2'd0;
    else               rh = m_cur[5:4];
    rv = !m5 ? 2'd0 : (!m2 ? 2'd1 : 2'd2);
    il = m_int_valid && (intf != m_prev_int);
    m_prev_int  = intf;
    m_int_valid = 1'b1;
    cand = {rh, rv, p, il};
    stb  = 1'b0;
    if (m_mute_left > 0) begin
      m_mute_left--;
      if (m_mute_left == 0) m_blank = 1'b0;
      m_run = 0;
    end else begin
      if (cand == m_cur) begin
        m_run = 0;
      end else if (m_run > 0 && cand == m_last) begin
        m_run++;
      end else begin
        m_last = cand;
        m_run  = 1;
      end
      if (m_run == STABLE) begin
        m_cur       = cand;
        stb         = 1'b1;
        m_blank     = 1'b1;
        m_mute_left = MUTEF;
        m_run       = 0;
        commit_q.push_back(cand);
      end
    end
    frame_q.push_back({m_cur, m_blank, stb});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int w);
    int n;
    hs_in = 1'b0;
    tick();
    hs_in = 1'b1;
    tick();
    n = 0;
    while (n < w) begin
      ce_pix   = ($urandom_range(0, 3) != 0);
      vdp_de_h = 1'b1;
      tick();
      if (ce_pix) n++;
    end
    vdp_de_h = 1'b0;
    ce_pix   = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_frame(input int wa, input int wb, input bit simul, input bit m5,
                           input bit m2, input bit intf, input bit p);
    vdp_m5       = m5;
    vdp_m2       = m2;
    vdp_intfield = intf;
    pal          = p;
    line(wa);
    line(wb);
    model_frame(wa, wb, m5, m2, intf, p);
    if (simul) begin
      hs_in = 1'b0;
      vs_in = 1'b0;
    end else begin
      hs_in = 1'b0;
      tick();
      hs_in = 1'b1;
      tick();
      vs_in = 1'b0;
    end
    tick();
    hs_in = 1'b1;
    tick();
    tick();
    vs_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic frames(input int n, input int wa, input int wb, input bit simul,
                        input bit m5, input bit m2, input bit tog, input bit p);
    for (int i = 0; i < n; i++) begin
      if (tog) itf = ~itf;
      run_frame(wa, wb, simul, m5, m2, itf, p);
    end
  endtask

  // Frame monitor: outputs settle two cycles after each vs falling edge.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge vs_in);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      if (frame_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_outputs: frame event with no expected entry at %0t", $time);
      end else begin
        exp = frame_q.pop_front();
        check("frame_outputs", {res_h, res_v, pal_out, interlace, blank_force, mode_stb}, exp);
      end
      @(negedge clk);
      check("stb_single_cycle", mode_stb, 1'b0);
    end
  end

  // Commit monitor: every strobe must match the next predicted commit.
  initial begin
    forever begin
      @(negedge clk);
      if (mode_stb) begin
        if (commit_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL commit_mode: unexpected strobe with mode %0h at %0t",
                   {res_h, res_v, pal_out, interlace}, $time);
        end else begin
          check("commit_mode", {res_h, res_v, pal_out, interlace}, commit_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  tw;
    bit  rm5, rm2, rp, tog;
    int  wtab[8];
    wtab = '{0, 120, 248, 252, 253, 300, 301, 520};

    model_reset();
    repeat (3) tick();
    check("reset_outputs", {res_h, res_v, pal_out, interlace, blank_force, mode_stb}, 8'b10_10_0_0_0_0);
    reset = 1'b0;
    tick();

    // Steady 320 stream, then width switch to 256 and back.
    frames(2, 320, 40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frames(5, 256, 40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frames(5, 320, 40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Single-frame glitch.
    frames(2, 320, 40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frames(1, 256, 40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frames(2, 320, 40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Retarget while pending.
    frames(2, 256, 40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frames(5, 248, 40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Interlace with 224-line mode, then frames without any display pixels.
    frames(5, 248, 40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    frames(3, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // Last line's count arrives on the same cycle as vsync.
    frames(3, 0, 320, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    check("blank_before_reset", blank_force, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("blank_after_reset", blank_force, 1'b0);
    check("outputs_after_reset", {res_h, res_v, pal_out, interlace, mode_stb}, 7'b10_10_0_0_0);
    model_reset();
    tick();
    reset = 1'b0;
    tick();

    tw  = 320;
    rm5 = 1'b1;
    rm2 = 1'b1;
    rp  = 1'b0;
    tog = 1'b0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) tw = wtab[$urandom_range(0, 7)];
      if ($urandom_range(0, 5) == 0) begin
        rm5 = 1'($urandom_range(0, 1));
        rm2 = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 7) == 0) rp = ~rp;
      if ($urandom_range(0, 7) == 0) tog = ~tog;
      frames(1, tw, int'($urandom_range(0, 100)), 1'($urandom_range(0, 1)), rm5, rm2, tog, rp);
    end

    repeat (10) tick();
    check("frame_queue_drained", frame_q.size(), 0);
    check("commit_queue_drained", commit_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
